// File: rtl/cr16_pkg.sv
// Shared CR16 control constants: state encodings, opcode/ext fields, condition codes, flag indices, ALU ops.
// Latency: none (declarations and pure helper functions only).
// Backpressure: not applicable.
package cr16_pkg;

    // Controller state encodings (exposed on state_dbg)
    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_EX_R    = 4'd2;
    localparam logic [3:0] ST_EX_I    = 4'd3;
    localparam logic [3:0] ST_MEM_ADR = 4'd4;
    localparam logic [3:0] ST_MEM_RD  = 4'd5;
    localparam logic [3:0] ST_MEM_WB  = 4'd6;
    localparam logic [3:0] ST_MEM_WR  = 4'd7;
    localparam logic [3:0] ST_BR      = 4'd8;
    localparam logic [3:0] ST_JMP     = 4'd9;
    localparam logic [3:0] ST_TRAP    = 4'd10;

    // Primary opcodes, instr[15:12]
    localparam logic [3:0] OPC_RTYPE = 4'h0;
    localparam logic [3:0] OPC_ANDI  = 4'h1;
    localparam logic [3:0] OPC_ORI   = 4'h2;
    localparam logic [3:0] OPC_XORI  = 4'h3;
    localparam logic [3:0] OPC_MEM   = 4'h4;
    localparam logic [3:0] OPC_ADDI  = 4'h5;
    localparam logic [3:0] OPC_ADDUI = 4'h6;
    localparam logic [3:0] OPC_ADDCI = 4'h7;
    localparam logic [3:0] OPC_LSHI  = 4'h8;
    localparam logic [3:0] OPC_SUBI  = 4'h9;
    localparam logic [3:0] OPC_SUBCI = 4'hA;
    localparam logic [3:0] OPC_CMPI  = 4'hB;
    localparam logic [3:0] OPC_BCOND = 4'hC;
    localparam logic [3:0] OPC_MOVI  = 4'hD;

    // Extended opcodes under OPC_MEM, instr[7:4]
    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_JCOND = 4'hC;

    // Condition codes, instr[11:8]
    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_GE = 4'hC;
    localparam logic [3:0] CC_LT = 4'hD;
    localparam logic [3:0] CC_UC = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    // Flag bit positions within flags[4:0] = {C,Z,F,L,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_N = 0;

    localparam logic [7:0] ALU_ADD = 8'h05;

    function automatic logic is_imm_opc(input logic [3:0] opc);
        return (opc == OPC_ANDI)  || (opc == OPC_ORI)   || (opc == OPC_XORI)  ||
               (opc == OPC_ADDI)  || (opc == OPC_ADDUI) || (opc == OPC_ADDCI) ||
               (opc == OPC_LSHI)  || (opc == OPC_SUBI)  || (opc == OPC_SUBCI) ||
               (opc == OPC_CMPI)  || (opc == OPC_MOVI);
    endfunction

    // Logical immediates take a zero-extended operand
    function automatic logic is_logical_opc(input logic [3:0] opc);
        return (opc == OPC_ANDI) || (opc == OPC_ORI) || (opc == OPC_XORI);
    endfunction

endpackage

// File: rtl/cr16_control_fsm_if.sv
// Control bundle between the CR16 controller (master) and the datapath/memory (slave).
// Latency: none (wiring only).
// Backpressure: none; memory stalls are absorbed by the controller's MEM_WAIT counter.
interface cr16_control_fsm_if;
    logic [15:0] instr;
    logic [4:0]  flags;
    logic        ir_load;
    logic        pcen;
    logic        branch;
    logic        jump;
    logic        jal;
    logic        regwrt;
    logic        memtoreg;
    logic        mem_rd;
    logic        mem_wr;
    logic        im_mux;
    logic        pc_mux;
    logic [1:0]  alusrcb;
    logic [7:0]  op;
    logic        illegal;
    logic [3:0]  state_dbg;

    modport master (
        input  instr, flags,
        output ir_load, pcen, branch, jump, jal, regwrt, memtoreg, mem_rd, mem_wr,
               im_mux, pc_mux, alusrcb, op, illegal, state_dbg
    );

    modport slave (
        output instr, flags,
        input  ir_load, pcen, branch, jump, jal, regwrt, memtoreg, mem_rd, mem_wr,
               im_mux, pc_mux, alusrcb, op, illegal, state_dbg
    );
endinterface

// File: rtl/cr16_cond_eval.sv
// Evaluates a 4-bit CR16 condition code against the live ALU flags; shared by branch and jump.
// Latency: combinational.
// Backpressure: none.
module cr16_cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    // F and L are carried on the flag bus but no condition code looks at them
    logic unused_flags;
    assign unused_flags = flags[FLAG_F] ^ flags[FLAG_L];

    // Condition table; reserved codes are never taken
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken = flags[FLAG_Z];
            CC_NE:   taken = !flags[FLAG_Z];
            CC_CS:   taken = flags[FLAG_C];
            CC_CC:   taken = !flags[FLAG_C];
            CC_GT:   taken = flags[FLAG_N];
            CC_LE:   taken = !flags[FLAG_N];
            CC_GE:   taken = flags[FLAG_N] | flags[FLAG_Z];
            CC_LT:   taken = !(flags[FLAG_N] | flags[FLAG_Z]);
            CC_UC:   taken = 1'b1;
            CC_NV:   taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_control_fsm.sv
// CR16 multicycle controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing of datapath strobes.
// Latency: R/I/branch/jump 3 cycles, STOR 4, LOAD 5, plus MEM_WAIT per memory access.
// Backpressure: none; slow memory handled by MEM_WAIT stall cycles. Option macro: CR16_CTRL_ILLEGAL_TRAP_EN.
module cr16_control_fsm
    import cr16_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
)
(
    input  logic                  clk,
    input  logic                  reset,
    cr16_control_fsm_if.master    bus
);

    localparam logic [3:0] WAIT_MAX = MEM_WAIT[3:0];

    logic [3:0]  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  decode_target;
    logic        wait_done;
    logic        cond_taken;

    logic [3:0] ir_opc, ir_cond, ir_ext;
    assign ir_opc  = ir_q[15:12];
    assign ir_cond = ir_q[11:8];
    assign ir_ext  = ir_q[7:4];

    // The source register field is consumed by the datapath, not by the controller
    logic unused_rsrc;
    assign unused_rsrc = ^ir_q[3:0];

    assign wait_done = (wait_q == WAIT_MAX);

    cr16_cond_eval u_cond_eval (
        .cond  (ir_cond),
        .flags (bus.flags),
        .taken (cond_taken)
    );

    // Instruction class -> first execute state; undecodable words trap or fall back to FETCH
    always_comb begin
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
        decode_target = ST_TRAP;
`else
        decode_target = ST_FETCH;
`endif
        if (ir_opc == OPC_RTYPE) begin
            decode_target = ST_EX_R;
        end else if (ir_opc == OPC_BCOND) begin
            decode_target = ST_BR;
        end else if (ir_opc == OPC_MEM) begin
            if ((ir_ext == EXT_LOAD) || (ir_ext == EXT_STOR)) begin
                decode_target = ST_MEM_ADR;
            end else if ((ir_ext == EXT_JCOND) || (ir_ext == EXT_JAL)) begin
                decode_target = ST_JMP;
            end
        end else if (is_imm_opc(ir_opc)) begin
            decode_target = ST_EX_I;
        end
    end

    // Next state, memory wait counter (cleared on every state change) and IR capture
    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                if (wait_done) begin
                    ir_d    = bus.instr;
                    state_d = ST_DECODE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_DECODE:  state_d = decode_target;
            ST_MEM_ADR: state_d = (ir_ext == EXT_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (wait_done) state_d = ST_MEM_WB;
                else           wait_d  = wait_q + 4'd1;
            end
            ST_MEM_WR: begin
                if (wait_done) state_d = ST_FETCH;
                else           wait_d  = wait_q + 4'd1;
            end
            ST_EX_R, ST_EX_I, ST_MEM_WB, ST_BR, ST_JMP: state_d = ST_FETCH;
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP:    state_d = ST_TRAP;
`else
            ST_TRAP:    state_d = ST_FETCH;
`endif
            default:    state_d = ST_FETCH;
        endcase
    end

    // State registers with synchronous reset; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            wait_q  <= 4'd0;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ir_q    <= ir_d;
        end
    end

    // Moore output decode; held at zero while reset is asserted so no write leaks out
    always_comb begin
        bus.ir_load   = 1'b0;
        bus.pcen      = 1'b0;
        bus.branch    = 1'b0;
        bus.jump      = 1'b0;
        bus.jal       = 1'b0;
        bus.regwrt    = 1'b0;
        bus.memtoreg  = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.im_mux    = 1'b0;
        bus.pc_mux    = 1'b0;
        bus.alusrcb   = 2'b00;
        bus.op        = 8'h00;
        bus.illegal   = 1'b0;
        bus.state_dbg = state_q;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_rd  = 1'b1;
                    bus.ir_load = wait_done;
                    bus.pcen    = wait_done;
                end
                ST_EX_R: begin
                    bus.op     = {4'h0, ir_ext};
                    bus.regwrt = 1'b1;
                end
                ST_EX_I: begin
                    bus.op      = {ir_opc, 4'h0};
                    bus.im_mux  = 1'b1;
                    bus.alusrcb = is_logical_opc(ir_opc) ? 2'b11 : 2'b10;
                    bus.regwrt  = 1'b1;
                end
                ST_MEM_ADR: bus.op = ALU_ADD;
                ST_MEM_RD:  bus.mem_rd = 1'b1;
                ST_MEM_WB: begin
                    bus.regwrt   = 1'b1;
                    bus.memtoreg = 1'b1;
                end
                ST_MEM_WR:  bus.mem_wr = 1'b1;
                ST_BR: begin
                    bus.pc_mux = 1'b1;
                    bus.branch = cond_taken;
                end
                ST_JMP: begin
                    if (ir_ext == EXT_JAL) begin
                        bus.jump   = 1'b1;
                        bus.jal    = 1'b1;
                        bus.regwrt = 1'b1;
                    end else begin
                        bus.jump = cond_taken;
                    end
                end
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
                ST_TRAP:    bus.illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Self-checking bench for cr16_control_fsm: two instances (MEM_WAIT 0 and 2) checked one at a time.
// Expected per-cycle control vectors come from an instruction-level model of the sequencing rules.
// Random instruction streams plus directed ADD/LOAD/branch/JAL/reset/illegal cases.
module tb_cr16_control_fsm;
    import cr16_pkg::*;

    typedef struct packed {
        logic       ir_load;
        logic       pcen;
        logic       branch;
        logic       jump;
        logic       jal;
        logic       regwrt;
        logic       memtoreg;
        logic       mem_rd;
        logic       mem_wr;
        logic       im_mux;
        logic       pc_mux;
        logic [1:0] alusrcb;
        logic [7:0] op;
        logic       illegal;
        logic [3:0] state_dbg;
    } ctl_t;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JC = 5, K_JAL = 6, K_BAD = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst2, sel;
    logic [15:0] instr_drv;
    logic [4:0]  flags_drv;

    cr16_control_fsm_if bus0();
    cr16_control_fsm_if bus2();

    assign bus0.instr = instr_drv;
    assign bus0.flags = flags_drv;
    assign bus2.instr = instr_drv;
    assign bus2.flags = flags_drv;

    cr16_control_fsm #(.MEM_WAIT(0)) u_dut0 (.clk(clk), .reset(rst0), .bus(bus0));
    cr16_control_fsm #(.MEM_WAIT(2)) u_dut2 (.clk(clk), .reset(rst2), .bus(bus2));

    ctl_t obs0, obs2, obs;
    always_comb begin
        obs0 = '{ir_load: bus0.ir_load, pcen: bus0.pcen, branch: bus0.branch, jump: bus0.jump,
                 jal: bus0.jal, regwrt: bus0.regwrt, memtoreg: bus0.memtoreg, mem_rd: bus0.mem_rd,
                 mem_wr: bus0.mem_wr, im_mux: bus0.im_mux, pc_mux: bus0.pc_mux, alusrcb: bus0.alusrcb,
                 op: bus0.op, illegal: bus0.illegal, state_dbg: bus0.state_dbg};
        obs2 = '{ir_load: bus2.ir_load, pcen: bus2.pcen, branch: bus2.branch, jump: bus2.jump,
                 jal: bus2.jal, regwrt: bus2.regwrt, memtoreg: bus2.memtoreg, mem_rd: bus2.mem_rd,
                 mem_wr: bus2.mem_wr, im_mux: bus2.im_mux, pc_mux: bus2.pc_mux, alusrcb: bus2.alusrcb,
                 op: bus2.op, illegal: bus2.illegal, state_dbg: bus2.state_dbg};
        obs  = sel ? obs2 : obs0;
    end

    int         passed = 0;
    int         total  = 0;
    logic [4:0] fl [0:15];
    ctl_t       exp_q[$];

    function automatic int classify(input logic [15:0] ins);
        logic [3:0] opc, ext;
        opc = ins[15:12];
        ext = ins[7:4];
        if (opc == 4'h0) return K_R;
        if (opc == 4'hC) return K_BR;
        if (opc == 4'h4) begin
            if (ext == 4'h0) return K_LD;
            if (ext == 4'h4) return K_ST;
            if (ext == 4'hC) return K_JC;
            if (ext == 4'h8) return K_JAL;
            return K_BAD;
        end
        if (opc inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD}) return K_I;
        return K_BAD;
    endfunction

    // flags = {C,Z,F,L,N}
    function automatic logic cond_true(input logic [3:0] cc, input logic [4:0] f);
        logic c, z, n;
        c = f[4];
        z = f[3];
        n = f[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h6: return n;
            4'h7: return !n;
            4'hC: return n | z;
            4'hD: return !(n | z);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctl_t idle(input logic [3:0] st);
        ctl_t c;
        c = '0;
        c.state_dbg = st;
        return c;
    endfunction

    // Expected cycle-by-cycle control vectors for one instruction with w memory wait cycles
    task automatic build(input logic [15:0] ins, input int w);
        ctl_t c;
        int   cls;
        exp_q.delete();
        cls = classify(ins);
        for (int i = 0; i < w; i++) begin
            c = idle(ST_FETCH); c.mem_rd = 1'b1; exp_q.push_back(c);
        end
        c = idle(ST_FETCH); c.mem_rd = 1'b1; c.ir_load = 1'b1; c.pcen = 1'b1; exp_q.push_back(c);
        exp_q.push_back(idle(ST_DECODE));
        case (cls)
            K_R: begin
                c = idle(ST_EX_R); c.op = {4'h0, ins[7:4]}; c.regwrt = 1'b1; exp_q.push_back(c);
            end
            K_I: begin
                c = idle(ST_EX_I); c.op = {ins[15:12], 4'h0}; c.im_mux = 1'b1; c.regwrt = 1'b1;
                c.alusrcb = (ins[15:12] inside {4'h1, 4'h2, 4'h3}) ? 2'b11 : 2'b10;
                exp_q.push_back(c);
            end
            K_LD, K_ST: begin
                c = idle(ST_MEM_ADR); c.op = 8'h05; exp_q.push_back(c);
                for (int i = 0; i <= w; i++) begin
                    if (cls == K_LD) begin c = idle(ST_MEM_RD); c.mem_rd = 1'b1; end
                    else             begin c = idle(ST_MEM_WR); c.mem_wr = 1'b1; end
                    exp_q.push_back(c);
                end
                if (cls == K_LD) begin
                    c = idle(ST_MEM_WB); c.regwrt = 1'b1; c.memtoreg = 1'b1; exp_q.push_back(c);
                end
            end
            K_BR: begin
                c = idle(ST_BR); c.pc_mux = 1'b1;
                c.branch = cond_true(ins[11:8], fl[exp_q.size()]);
                exp_q.push_back(c);
            end
            K_JC: begin
                c = idle(ST_JMP); c.jump = cond_true(ins[11:8], fl[exp_q.size()]); exp_q.push_back(c);
            end
            K_JAL: begin
                c = idle(ST_JMP); c.jump = 1'b1; c.jal = 1'b1; c.regwrt = 1'b1; exp_q.push_back(c);
            end
            default: begin
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++) begin
                    c = idle(ST_TRAP); c.illegal = 1'b1; exp_q.push_back(c);
                end
`endif
            end
        endcase
    endtask

    task automatic check(input string tag, input ctl_t o, input ctl_t e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    // Entered and left just after a rising edge; lim < 0 runs the whole instruction
    task automatic run_instr(input string tag, input logic [15:0] ins, input int w,
                             input logic fix, input logic [4:0] ffl, input int lim);
        int n;
        for (int i = 0; i < 16; i++) fl[i] = fix ? ffl : 5'($urandom);
        build(ins, w);
        n = exp_q.size();
        if (lim >= 0 && lim < n) n = lim;
        for (int k = 0; k < n; k++) begin
            instr_drv = (k <= w) ? ins : 16'($urandom);
            flags_drv = fl[k];
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, k), obs, exp_q[k]);
            @(posedge clk);
            #1;
        end
    endtask

    // Reset held across one edge: controller must sit in FETCH with every strobe low
    task automatic pulse_reset(input string tag);
        if (sel) rst2 = 1'b1; else rst0 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check(tag, obs, idle(ST_FETCH));
        @(posedge clk);
        #1;
        if (sel) rst2 = 1'b0; else rst0 = 1'b0;
    endtask

    function automatic logic [15:0] gen_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: r[15:12] = 4'h0;
            1: r[15:12] = 4'h4;
            2: begin r[15:12] = 4'h4; r[7:4] = 4'h0; end
            3: begin r[15:12] = 4'h4; r[7:4] = 4'h4; end
            4: begin r[15:12] = 4'h4; r[7:4] = 4'hC; end
            5: begin r[15:12] = 4'h4; r[7:4] = 4'h8; end
            6: r[15:12] = 4'hC;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [15:0] ins;
        rst0 = 1'b1;
        rst2 = 1'b1;
        sel = 1'b0;
        instr_drv = 16'h0000;
        flags_drv = 5'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_w0", obs, idle(ST_FETCH));
        sel = 1'b1;
        #1;
        check("reset_w2", obs, idle(ST_FETCH));
        sel = 1'b0;
        @(posedge clk);
        #1;
        rst0 = 1'b0;

        // MEM_WAIT = 0 instance
        run_instr("add",      16'h0152, 0, 1'b1, 5'b00000, -1);
        run_instr("beq_z1",   16'hC005, 0, 1'b1, 5'b01000, -1);
        run_instr("beq_z0",   16'hC005, 0, 1'b1, 5'b10111, -1);
        run_instr("bnever",   16'hCF05, 0, 1'b1, 5'b11111, -1);
        run_instr("jal_f0",   16'h4A83, 0, 1'b1, 5'b00000, -1);
        run_instr("jal_f1",   16'h4A83, 0, 1'b1, 5'b11111, -1);
        run_instr("jeq",      16'h40C3, 0, 1'b1, 5'b01000, -1);
        run_instr("ori",      16'h2312, 0, 1'b1, 5'b00000, -1);
        run_instr("addi",     16'h5312, 0, 1'b1, 5'b00000, -1);
        run_instr("stor",     16'h4145, 0, 1'b1, 5'b00000, -1);
        run_instr("load",     16'h4304, 0, 1'b1, 5'b00000, -1);
        run_instr("illegal",  16'hF000, 0, 1'b1, 5'b00000, -1);
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
        pulse_reset("trap_rst_w0");
`endif
        run_instr("post_ill", 16'h0152, 0, 1'b1, 5'b00000, -1);
        for (int n = 0; n < 60; n++) begin
            ins = gen_instr();
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
            while (classify(ins) == K_BAD) ins = gen_instr();
`endif
            run_instr($sformatf("rnd0_%0d_%h", n, ins), ins, 0, 1'b0, 5'b00000, -1);
        end

        // MEM_WAIT = 2 instance
        rst0 = 1'b1;
        sel = 1'b1;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        run_instr("load_w2", 16'h4304, 2, 1'b1, 5'b00000, -1);
        run_instr("add_w2",  16'h0152, 2, 1'b1, 5'b00000, -1);
        run_instr("stor_w2", 16'h4145, 2, 1'b1, 5'b00000, -1);
        run_instr("bne_w2",  16'hC105, 2, 1'b1, 5'b00000, -1);
        // Stop after the first MEM_WR cycle and reset while the store is still in progress
        run_instr("wr_abort", 16'h4145, 2, 1'b1, 5'b00000, 6);
        pulse_reset("rst_in_memwr");
        run_instr("post_rst_w2", 16'h0152, 2, 1'b1, 5'b00000, -1);
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
        run_instr("illegal_w2", 16'hF000, 2, 1'b1, 5'b00000, -1);
        pulse_reset("trap_rst_w2");
`endif
        for (int n = 0; n < 40; n++) begin
            ins = gen_instr();
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
            while (classify(ins) == K_BAD) ins = gen_instr();
`endif
            run_instr($sformatf("rnd2_%0d_%h", n, ins), ins, 2, 1'b0, 5'b00000, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
